cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Parametrised successor to the fixed CPU control/instruction-pointer pair: multi-cycle control FSM plus
//  program counter, with req/ack handshakes to instruction fetch and data memory/ports (wait states),
//  signed branch offsets of configurable width, a halt request, and a bus-timeout fault.
//  Sits between the decoder (consumes instruction-class flags) and reg stack/ALU (drives phase strobes).
// PARAMETERS
//  ADDR_WIDTH    16  pointer width; all pointer arithmetic is modulo 2^ADDR_WIDTH
//  OFFSET_WIDTH  8   branch/jump offset width, two's complement, sign-extended to ADDR_WIDTH
//  RESET_VECTOR  0   pointer value loaded on reset
//  MAX_WAIT      255 max cycles a req may wait for ack before fault; 0 = never time out
// PORTS
//  clk           in   1             clock, all state changes on rising edge
//  reset         in   1             synchronous, active-high
//  fetch_req     out  1             instruction fetch request, held until fetch_ack
//  fetch_ack     in   1             fetch complete this cycle
//  pointer       out  ADDR_WIDTH    current instruction address
//  cls_alu       in   1             decoded: ALU op
//  cls_load      in   1             decoded: memory/port read
//  cls_store     in   1             decoded: memory/port write
//  cls_jump      in   1             decoded: unconditional relative jump
//  cls_branch    in   1             decoded: conditional relative branch
//  branch_cond   in   1             branch condition (register != 0), valid REGLOAD..NEXT
//  offset        in   OFFSET_WIDTH  relative offset for jump/branch
//  halt_req      in   1             stop after current instruction retires
//  mem_req       out  1             data access request, held until mem_ack
//  mem_we        out  1             1 = write (store), valid while mem_req
//  mem_ack       in   1             data access complete this cycle
//  do_regload    out  1             one-cycle strobe: read register operands
//  do_aluop      out  1             one-cycle strobe: ALU evaluate
//  do_regstore   out  1             one-cycle strobe: write result register
//  state         out  3             current FSM state encoding (below)
//  fault         out  1             sticky: bus timeout occurred
// BEHAVIOUR
//  States: RST=0 FETCH=1 REGLOAD=2 ALU=3 MEM=4 REGSTORE=5 NEXT=6 HALT=7.
//  reset (any state, any cycle, incl. mid-handshake): state<=RST, pointer<=RESET_VECTOR, fault<=0,
//   wait counter<=0; all req/strobe outputs 0 during RST (outputs decode from state, no extra latency).
//  RST -> FETCH unconditionally next cycle.
//  FETCH: fetch_req=1. ack sampled high on an edge -> REGLOAD (zero-wait fetch = 1 cycle).
//  REGLOAD: do_regload=1 for 1 cycle. Next by priority: cls_alu->ALU; cls_load|cls_store->MEM;
//   cls_jump|cls_branch->NEXT; no flag set->REGSTORE (immediate loads).
//  ALU: do_aluop=1 1 cycle -> REGSTORE.
//  MEM: mem_req=1, mem_we=cls_store&~cls_load. On mem_ack: load->REGSTORE, store->NEXT.
//  REGSTORE: do_regstore=1 1 cycle -> NEXT.
//  NEXT: pointer <= pointer + sext(offset) if cls_jump | (cls_branch & branch_cond), else pointer+1;
//   wraps modulo 2^ADDR_WIDTH. Then halt_req ? HALT : FETCH. halt_req ignored in all other states.
//  HALT: all req/strobes 0, pointer frozen; left only by reset.
//  Wait counter: cleared on entry to FETCH/MEM and on ack; increments each cycle req held without ack.
//   If MAX_WAIT!=0 and counter reaches MAX_WAIT with no ack -> fault<=1, state<=HALT, req drops.
//   Ack on the same edge the counter would reach MAX_WAIT wins (no fault).
//  ack inputs ignored outside their own state. Class flags/offset/branch_cond must be stable
//   REGLOAD..NEXT; multiple flags resolved by the priority above.
//  Cycle count, zero-wait acks: ALU 5, load 5, store 4, jump/branch 3, immediate 4.
// TESTING
//  reset, fetch_ack=mem_ack=1, cls_alu=1 -> states 0,1,2,3,5,6,1; do_aluop/do_regstore one cycle each; pointer 0->1.
//  pointer=0x0010, cls_branch=1, branch_cond=1, offset=0xFE -> pointer 0x000E; branch_cond=0 -> 0x0011.
//  RESET_VECTOR=0xFFFF, cls_jump=0 -> after NEXT pointer=0x0000 (wrap); offset=0x7F from 0xFFF0 -> 0x006F.
//  cls_load, mem_ack delayed 3 cycles -> mem_req high exactly 4 cycles, then REGSTORE, fault=0.
//  MAX_WAIT=4, fetch_ack never -> fault=1, state=7 after 4 waiting cycles; pointer unchanged.
//  reset asserted while in MEM with mem_req=1 -> next cycle state=0, mem_req=0, pointer=RESET_VECTOR.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control FSM and program counter with fetch/data handshakes,
// signed relative branches, halt request and a sticky bus-timeout fault.
module cpu_sequencer #(
  parameter int unsigned            ADDR_WIDTH   = 16,
  parameter int unsigned            OFFSET_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned            MAX_WAIT     = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    fetch_req,
  input  logic                    fetch_ack,
  output logic [ADDR_WIDTH-1:0]   pointer,
  input  logic                    cls_alu,
  input  logic                    cls_load,
  input  logic                    cls_store,
  input  logic                    cls_jump,
  input  logic                    cls_branch,
  input  logic                    branch_cond,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic                    halt_req,
  output logic                    mem_req,
  output logic                    mem_we,
  input  logic                    mem_ack,
  output logic                    do_regload,
  output logic                    do_aluop,
  output logic                    do_regstore,
  output logic [2:0]              state,
  output logic                    fault
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    S_RST      = 3'd0,
    S_FETCH    = 3'd1,
    S_REGLOAD  = 3'd2,
    S_ALU      = 3'd3,
    S_MEM      = 3'd4,
    S_REGSTORE = 3'd5,
    S_NEXT     = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_pointer;
  logic [ADDR_WIDTH-1:0]   w_pointer_next;
  logic [WAIT_W-1:0]       r_wait;
  logic [WAIT_W-1:0]       w_wait_next;
  logic [WAIT_W-1:0]       w_wait_inc;
  logic                    r_fault;
  logic                    w_fault_next;
  logic                    w_timeout;
  logic                    w_take;
  logic [ADDR_WIDTH-1:0]   w_offset_ext;

  assign w_wait_inc   = r_wait + WAIT_W'(1);
  // Timeout fires on the edge the counter would reach MAX_WAIT; an ack on that edge takes precedence.
  assign w_timeout    = (MAX_WAIT != 0) && (w_wait_inc == WAIT_W'(MAX_WAIT));
  assign w_offset_ext = ADDR_WIDTH'(signed'(offset));
  assign w_take       = cls_jump | (cls_branch & branch_cond);

  always_comb begin
    w_next_state   = r_state;
    w_pointer_next = r_pointer;
    w_wait_next    = r_wait;
    w_fault_next   = r_fault;
    fetch_req      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    do_regload     = 1'b0;
    do_aluop       = 1'b0;
    do_regstore    = 1'b0;
    case (r_state)
      S_RST: begin
        w_next_state = S_FETCH;
        w_wait_next  = '0;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          w_next_state = S_REGLOAD;
          w_wait_next  = '0;
        end else if (w_timeout) begin
          w_fault_next = 1'b1;
          w_next_state = S_HALT;
          w_wait_next  = '0;
        end else begin
          w_wait_next = w_wait_inc;
        end
      end
      S_REGLOAD: begin
        do_regload  = 1'b1;
        w_wait_next = '0;
        if (cls_alu)                   w_next_state = S_ALU;
        else if (cls_load | cls_store) w_next_state = S_MEM;
        else if (cls_jump | cls_branch) w_next_state = S_NEXT;
        else                           w_next_state = S_REGSTORE;
      end
      S_ALU: begin
        do_aluop     = 1'b1;
        w_next_state = S_REGSTORE;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = cls_store & ~cls_load;
        if (mem_ack) begin
          w_next_state = cls_load ? S_REGSTORE : S_NEXT;
          w_wait_next  = '0;
        end else if (w_timeout) begin
          w_fault_next = 1'b1;
          w_next_state = S_HALT;
          w_wait_next  = '0;
        end else begin
          w_wait_next = w_wait_inc;
        end
      end
      S_REGSTORE: begin
        do_regstore  = 1'b1;
        w_next_state = S_NEXT;
      end
      S_NEXT: begin
        w_pointer_next = w_take ? (r_pointer + w_offset_ext)
                                : (r_pointer + ADDR_WIDTH'(1));
        w_next_state   = halt_req ? S_HALT : S_FETCH;
        w_wait_next    = '0;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RST;
      r_pointer <= RESET_VECTOR;
      r_wait    <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pointer <= w_pointer_next;
      r_wait    <= w_wait_next;
      r_fault   <= w_fault_next;
    end
  end

  assign pointer = r_pointer;
  assign state   = r_state;
  assign fault   = r_fault;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed instructions push expected retire
// records; a negedge monitor tallies per-instruction activity and compares on retire/halt.
module tb_cpu_sequencer;

  localparam logic [15:0] RV = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_ack;
  logic [15:0] pointer;
  logic        cls_alu, cls_load, cls_store, cls_jump, cls_branch, branch_cond;
  logic [7:0]  offset;
  logic        halt_req;
  logic        mem_req, mem_we, mem_ack;
  logic        do_regload, do_aluop, do_regstore;
  logic [2:0]  st;
  logic        fault;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .ADDR_WIDTH(16), .OFFSET_WIDTH(8), .RESET_VECTOR(RV), .MAX_WAIT(4)
  ) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .pointer(pointer), .cls_alu(cls_alu), .cls_load(cls_load), .cls_store(cls_store),
    .cls_jump(cls_jump), .cls_branch(cls_branch), .branch_cond(branch_cond),
    .offset(offset), .halt_req(halt_req), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .do_regload(do_regload), .do_aluop(do_aluop),
    .do_regstore(do_regstore), .state(st), .fault(fault)
  );

  typedef struct {
    string       name;
    logic [15:0] ptr;
    logic [2:0]  st;
    int          cyc, nfr, nrl, nalu, nrs, nmem, nwe;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   fdelay = 0;
  int   mdelay = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ack responder: ack after the request has been held for delay+1 cycles.
  initial begin
    int fc, mc;
    fc = 0; mc = 0; fetch_ack = 1'b0; mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (fetch_req) fc++; else fc = 0;
      if (mem_req)   mc++; else mc = 0;
      fetch_ack = fetch_req && (fc == fdelay + 1);
      mem_ack   = mem_req   && (mc == mdelay + 1);
    end
  end

  // Monitor: compares on the cycle after NEXT, or on a fault-driven entry to HALT.
  initial begin
    logic [2:0] prev_st;
    int cyc, nfr, nrl, nalu, nrs, nmem, nwe;
    exp_t e;
    prev_st = 3'd0;
    cyc = 0; nfr = 0; nrl = 0; nalu = 0; nrs = 0; nmem = 0; nwe = 0;
    forever begin
      @(negedge clk);
      if (prev_st == 3'd6 || (st == 3'd7 && (prev_st == 3'd1 || prev_st == 3'd4))) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire: state %0d with empty scoreboard", st);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".pointer"},  pointer, e.ptr);
          chk({e.name, ".state"},    st, e.st);
          chk({e.name, ".fault"},    fault, e.flt);
          chk({e.name, ".cycles"},   cyc, e.cyc);
          chk({e.name, ".fetchreq"}, nfr, e.nfr);
          chk({e.name, ".regload"},  nrl, e.nrl);
          chk({e.name, ".aluop"},    nalu, e.nalu);
          chk({e.name, ".regstore"}, nrs, e.nrs);
          chk({e.name, ".memreq"},   nmem, e.nmem);
          chk({e.name, ".memwe"},    nwe, e.nwe);
        end
        cyc = 0; nfr = 0; nrl = 0; nalu = 0; nrs = 0; nmem = 0; nwe = 0;
      end
      if (st == 3'd0) begin
        cyc = 0; nfr = 0; nrl = 0; nalu = 0; nrs = 0; nmem = 0; nwe = 0;
      end
      if (st >= 3'd1 && st <= 3'd6) cyc++;
      if (fetch_req)           nfr++;
      if (do_regload)          nrl++;
      if (do_aluop)            nalu++;
      if (do_regstore)         nrs++;
      if (mem_req)             nmem++;
      if (mem_req && mem_we)   nwe++;
      prev_st = st;
    end
  end

  // cls = {alu, load, store, jump, branch}
  task automatic instr(input string nm, input logic [4:0] cls, input logic cond,
                       input logic [7:0] off, input logic h, input int fd, input int md,
                       input logic [15:0] eptr, input logic [2:0] est, input int ecyc,
                       input int enfr, input int enrl, input int enalu, input int enrs,
                       input int enmem, input int enwe, input logic eflt);
    exp_t e;
    int n;
    e.name = nm; e.ptr = eptr; e.st = est; e.cyc = ecyc; e.nfr = enfr; e.nrl = enrl;
    e.nalu = enalu; e.nrs = enrs; e.nmem = enmem; e.nwe = enwe; e.flt = eflt;
    sb.push_back(e);
    {cls_alu, cls_load, cls_store, cls_jump, cls_branch} = cls;
    branch_cond = cond; offset = off; halt_req = h; fdelay = fd; mdelay = md;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(st == 3'd6 || st == 3'd7) && n < 60);
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL %s.timeout: state %0d after %0d cycles, need NEXT or HALT", nm, st, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1 reset = 1'b1;
    {cls_alu, cls_load, cls_store, cls_jump, cls_branch} = '0;
    halt_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".state"},   st, 3'd0);
    chk({nm, ".pointer"}, pointer, RV);
    chk({nm, ".fault"},   fault, 1'b0);
    chk({nm, ".outputs"}, {fetch_req, mem_req, do_regload, do_aluop, do_regstore}, 5'b0);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    {cls_alu, cls_load, cls_store, cls_jump, cls_branch} = '0;
    branch_cond = 1'b0; offset = '0; halt_req = 1'b0;
    do_reset("reset0");

    //     name          cls       c  off    h fd md  ptr       st cyc fr rl al rs mm we flt
    instr("imm_wrap",   5'b00000, 0, 8'h00, 0, 0, 0, 16'h0000, 1, 4, 1, 1, 0, 1, 0, 0, 0);
    instr("alu",        5'b10000, 0, 8'h00, 0, 0, 0, 16'h0001, 1, 5, 1, 1, 1, 1, 0, 0, 0);
    instr("jump_fwd",   5'b00010, 0, 8'h0F, 0, 0, 0, 16'h0010, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("br_taken",   5'b00001, 1, 8'hFE, 0, 0, 0, 16'h000E, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("jump_2",     5'b00010, 0, 8'h02, 0, 0, 0, 16'h0010, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("br_nottkn",  5'b00001, 0, 8'hFE, 0, 0, 0, 16'h0011, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("load_wait3", 5'b01000, 0, 8'h00, 0, 0, 3, 16'h0012, 1, 8, 1, 1, 0, 1, 4, 0, 0);
    instr("store",      5'b00100, 0, 8'h00, 0, 0, 0, 16'h0013, 1, 4, 1, 1, 0, 0, 1, 1, 0);
    instr("alu_fwait3", 5'b10000, 0, 8'h00, 0, 3, 0, 16'h0014, 1, 8, 4, 1, 1, 1, 0, 0, 0);
    instr("jump_m128",  5'b00010, 0, 8'h80, 0, 0, 0, 16'hFF94, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("jump_5c",    5'b00010, 0, 8'h5C, 0, 0, 0, 16'hFFF0, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("jump_7f",    5'b00010, 0, 8'h7F, 0, 0, 0, 16'h006F, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("prio_aluld", 5'b11000, 0, 8'h00, 0, 0, 0, 16'h0070, 1, 5, 1, 1, 1, 1, 0, 0, 0);
    instr("prio_ldst",  5'b01100, 0, 8'h00, 0, 0, 0, 16'h0071, 1, 5, 1, 1, 0, 1, 1, 0, 0);
    instr("store_w3",   5'b00100, 0, 8'h00, 0, 0, 3, 16'h0072, 1, 7, 1, 1, 0, 0, 4, 4, 0);
    instr("jmp_br_c0",  5'b00011, 0, 8'h03, 0, 0, 0, 16'h0075, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("br_minus1",  5'b00001, 1, 8'hFF, 0, 0, 0, 16'h0074, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    instr("imm_halt",   5'b00000, 0, 8'h00, 1, 0, 0, 16'h0075, 7, 4, 1, 1, 0, 1, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("halt_hold.state",   st, 3'd7);
    chk("halt_hold.pointer", pointer, 16'h0075);
    chk("halt_hold.reqs",    {fetch_req, mem_req, do_regload, do_aluop, do_regstore}, 5'b0);

    do_reset("reset1");
    instr("mem_timeout", 5'b01000, 0, 8'h00, 0, 0, 4, RV, 7, 6, 1, 1, 0, 0, 4, 0, 1);
    repeat (3) @(negedge clk);
    chk("mem_timeout.hold", {st, fault, pointer}, {3'd7, 1'b1, RV});

    do_reset("reset2");
    instr("fetch_timeout", 5'b00000, 0, 8'h00, 0, 1000, 0, RV, 7, 4, 4, 0, 0, 0, 0, 0, 1);

    do_reset("reset3");
    {cls_alu, cls_load, cls_store, cls_jump, cls_branch} = 5'b01000;
    fdelay = 0; mdelay = 1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (st != 3'd4 && n < 20);
    chk("midmem.reached", st, 3'd4);
    @(negedge clk);
    chk("midmem.memreq", mem_req, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midmem.state",   st, 3'd0);
    chk("midmem.memreq0", mem_req, 1'b0);
    chk("midmem.pointer", pointer, RV);
    chk("midmem.fault",   fault, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    {cls_alu, cls_load, cls_store, cls_jump, cls_branch} = '0;
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
